s3_maxpool_sequencer: RTL and testbench

//  Downstream of the s2 conv stage. Consumes the 144-entry feature map (4 filters x 6x6, signed, post-ReLU).

---
 rtl/s3_pkg.sv | 23 ++
 rtl/max4_signed.sv | 27 ++
 rtl/s3_maxpool_sequencer.sv | 178 +++++++++++++++++
 tb/tb_s3_maxpool_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s3_pkg.sv
// rtl/s3_pkg.sv - shared constants and types for the s3 max-pool stage
//
// Purpose : feature-map geometry, pooled-result count, data type and the
//           sequencer state encoding used by the s3 pooling stage.
// Ports   : none (package).

package s3_pkg;

   localparam int DW       = 36;
   localparam int N_FILT   = 4;
   localparam int FM_DIM   = 6;
   localparam int POOL_DIM = FM_DIM / 2;
   localparam int N_POOL   = N_FILT * POOL_DIM * POOL_DIM;

   typedef logic signed [DW-1:0] fmap_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2
   } pool_state_e;

endpackage

// File: rtl/max4_signed.sv
// rtl/max4_signed.sv - signed maximum of four values, lowest index wins ties
//
// Purpose : combinational two-level compare tree over one 2x2 pooling window.
// Ports   : in0..in3  in   DW  window values in fmap order b, b+1, b+6, b+7
//           max_out   out  DW  signed maximum of the four inputs

module max4_signed
   import s3_pkg::*;
#(
   parameter int DW = s3_pkg::DW
) (
   input  logic signed [DW-1:0] in0,
   input  logic signed [DW-1:0] in1,
   input  logic signed [DW-1:0] in2,
   input  logic signed [DW-1:0] in3,
   output logic signed [DW-1:0] max_out
);

   logic signed [DW-1:0] max01;
   logic signed [DW-1:0] max23;

   // Strict greater-than at every level keeps the lower-index operand on ties.
   assign max01   = (in1 > in0) ? in1 : in0;
   assign max23   = (in3 > in2) ? in3 : in2;
   assign max_out = (max23 > max01) ? max23 : max01;

endmodule

// File: rtl/s3_maxpool_sequencer.sv
// rtl/s3_maxpool_sequencer.sv - 2x2/stride-2 max-pool sequencer with streaming output
//
// Purpose : walks the pooled grid filter by filter, reduces each 2x2 window of
//           the feature map to its signed maximum, streams the results over a
//           valid/ready port and mirrors every accepted result into pool_res.
// Ports   : clk        in   1        rising-edge clock
//           rst_n      in   1        asynchronous active-low reset
//           start      in   1        request to pool the current fmap (ignored while busy)
//           fmap       in   DW x N   feature map, index f*FM_DIM^2 + r*FM_DIM + c
//           busy       out  1        run in progress, through the done cycle
//           done       out  1        one-cycle pulse after the last result is accepted
//           out_valid  out  1        out_data/out_idx hold a pooled result
//           out_ready  in   1        consumer accepts when out_valid && out_ready
//           out_data   out  DW       pooled maximum
//           out_idx    out  IDX_W    result index f*POOL_DIM^2 + pr*POOL_DIM + pc
//           pool_res   out  DW x M   copy of every accepted result

module s3_maxpool_sequencer
   import s3_pkg::*;
#(
   parameter int DW     = s3_pkg::DW,
   parameter int N_FILT = s3_pkg::N_FILT,
   parameter int FM_DIM = s3_pkg::FM_DIM
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic signed [DW-1:0] fmap [N_FILT*FM_DIM*FM_DIM],
   output logic                 busy,
   output logic                 done,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_data,
   output logic [$clog2(N_FILT*(FM_DIM/2)*(FM_DIM/2))-1:0] out_idx,
   output logic signed [DW-1:0] pool_res [N_FILT*(FM_DIM/2)*(FM_DIM/2)]
);

   localparam int P_DIM = FM_DIM / 2;
   localparam int N_RES = N_FILT * P_DIM * P_DIM;
   localparam int N_FM  = N_FILT * FM_DIM * FM_DIM;
   localparam int IDX_W = $clog2(N_RES);
   localparam int AW    = $clog2(N_FM);
   localparam int FW    = (N_FILT > 1) ? $clog2(N_FILT) : 1;
   localparam int PW    = (P_DIM > 1) ? $clog2(P_DIM) : 1;

   pool_state_e state, state_nxt;

   logic [FW-1:0]        f_cnt;
   logic [PW-1:0]        pr_cnt;
   logic [PW-1:0]        pc_cnt;
   logic [AW-1:0]        base;
   logic [IDX_W-1:0]     cur_idx;
   logic signed [DW-1:0] win_max;
   logic                 last_pos;
   logic                 accept;
   logic                 load;
   logic                 start_ok;
   logic                 finish;

   assign accept   = out_valid && out_ready;
   assign last_pos = (f_cnt  == FW'(N_FILT - 1)) &&
                     (pr_cnt == PW'(P_DIM - 1))  &&
                     (pc_cnt == PW'(P_DIM - 1));

   // Top-left corner of the current window and the matching result index.
   assign base    = AW'(int'(f_cnt) * FM_DIM * FM_DIM +
                        2 * FM_DIM * int'(pr_cnt) + 2 * int'(pc_cnt));
   assign cur_idx = IDX_W'(int'(f_cnt) * P_DIM * P_DIM +
                           int'(pr_cnt) * P_DIM + int'(pc_cnt));

   max4_signed #(
      .DW(DW)
   ) u_max4 (
      .in0    (fmap[base]),
      .in1    (fmap[base + AW'(1)]),
      .in2    (fmap[base + AW'(FM_DIM)]),
      .in3    (fmap[base + AW'(FM_DIM + 1)]),
      .max_out(win_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The first result is loaded on the start edge itself so out_valid rises
   // one cycle after start. In the done cycle the FSM is already IDLE but busy
   // is still high, which is what makes a start coinciding with done ignored.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      start_ok  = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !busy) begin
               start_ok  = 1'b1;
               load      = 1'b1;
               state_nxt = last_pos ? LAST : RUN;
            end
         end
         RUN: begin
            if (!out_valid || out_ready) begin
               load = 1'b1;
               if (last_pos) begin
                  state_nxt = LAST;
               end
            end
         end
         LAST: begin
            if (accept) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         f_cnt     <= '0;
         pr_cnt    <= '0;
         pc_cnt    <= '0;
         for (int i = 0; i < N_RES; i++) begin
            pool_res[i] <= '0;
         end
      end else begin
         done <= finish;

         if (start_ok) begin
            busy <= 1'b1;
         end else if (done) begin
            busy <= 1'b0;
         end

         if (accept) begin
            pool_res[out_idx] <= out_data;
         end

         if (load) begin
            out_data  <= win_max;
            out_idx   <= cur_idx;
            out_valid <= 1'b1;
            // pc is the fastest index; after the final window every counter
            // wraps back to zero, ready for the next run.
            if (pc_cnt == PW'(P_DIM - 1)) begin
               pc_cnt <= '0;
               if (pr_cnt == PW'(P_DIM - 1)) begin
                  pr_cnt <= '0;
                  if (f_cnt == FW'(N_FILT - 1)) begin
                     f_cnt <= '0;
                  end else begin
                     f_cnt <= f_cnt + FW'(1);
                  end
               end else begin
                  pr_cnt <= pr_cnt + PW'(1);
               end
            end else begin
               pc_cnt <= pc_cnt + PW'(1);
            end
         end else if (finish) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_s3_maxpool_sequencer.sv
// tb/tb_s3_maxpool_sequencer.sv - scoreboard bench for the s3 max-pool sequencer

module tb_s3_maxpool_sequencer;

   localparam logic signed [35:0] MAXP = 36'sh7_FFFF_FFFF;
   localparam logic signed [35:0] MINN = 36'sh8_0000_0000;

   typedef struct {
      logic [5:0]         idx;
      logic signed [35:0] data;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               out_ready;
   logic               busy;
   logic               done;
   logic               out_valid;
   logic signed [35:0] out_data;
   logic [5:0]         out_idx;
   logic signed [35:0] fmap [144];
   logic signed [35:0] pool_res [36];
   logic signed [35:0] gold [36];

   exp_t sbq [$];

   int tests = 0;
   int fails = 0;
   int acc_cnt = 0;
   int done_cnt = 0;
   int ready_mode = 0;
   int rphase = 0;
   logic [3:0] rpat = 4'b1001;

   bit                 hold_pend = 0;
   bit                 last_acc = 0;
   logic [5:0]         held_idx;
   logic signed [35:0] held_data;

   s3_maxpool_sequencer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .fmap     (fmap),
      .busy     (busy),
      .done     (done),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_idx  (out_idx),
      .pool_res (pool_res)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic signed [35:0] rnd36();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[35:0];
   endfunction

   // Reference: scan every feature-map cell and fold it into the pooled cell
   // it belongs to (row/2, col/2 within its filter).
   task automatic build_gold();
      bit seen [36];
      for (int k = 0; k < 36; k++) seen[k] = 0;
      for (int i = 0; i < 144; i++) begin
         int f, r, c, k;
         f = i / 36;
         r = (i % 36) / 6;
         c = i % 6;
         k = f * 9 + (r / 2) * 3 + (c / 2);
         if (!seen[k] || fmap[i] > gold[k]) begin
            gold[k] = fmap[i];
            seen[k] = 1;
         end
      end
      for (int k = 0; k < 36; k++) begin
         exp_t e;
         e.idx  = 6'(k);
         e.data = gold[k];
         sbq.push_back(e);
      end
   endtask

   task automatic check_pool_res();
      int mism;
      mism = 0;
      for (int k = 0; k < 36; k++) begin
         if (pool_res[k] !== gold[k]) begin
            if (mism == 0)
               $display("FAIL pool_res[%0d]: got %0d, expected %0d", k, pool_res[k], gold[k]);
            mism++;
         end
      end
      chk("pool_res_mismatches", mism, 0);
   endtask

   // Ready driver
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: begin
            out_ready = rpat[rphase % 4];
            rphase++;
         end
         default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 0;
         last_acc  = 0;
      end else begin
         if (done || last_acc) chk("done_timing", done, last_acc);
         if (done) done_cnt++;
         last_acc = 0;
         if (hold_pend) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_idx", out_idx, held_idx);
            chk("stall_data", out_data, held_data);
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_extra_beat: got idx %0d data %0d, expected no beat", out_idx, out_data);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("beat_idx", out_idx, e.idx);
               chk("beat_data", out_data, e.data);
               acc_cnt++;
               last_acc = (sbq.size() == 0);
            end
         end
         hold_pend = out_valid && !out_ready;
         held_idx  = out_idx;
         held_data = out_data;
      end
   end

   task automatic run_pool(input int mode, input bit start_mid, input bit start_done, input bit chk_lat);
      int  n;
      bit  fired;
      bit  got_done;
      ready_mode = mode;
      build_gold();
      acc_cnt  = 0;
      done_cnt = 0;
      fired    = 0;
      got_done = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("first_valid", out_valid, 1);
      chk("first_idx", out_idx, 0);
      chk("busy_running", busy, 1);
      for (n = 1; n <= 2000; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            got_done = 1;
            break;
         end
         if (start_mid && !fired && acc_cnt >= 10) begin
            start = 1'b1;
            fired = 1;
         end
      end
      if (!got_done) begin
         tests++;
         fails++;
         $display("FAIL run_timeout: got no done in 2000 cycles, expected done");
      end
      if (chk_lat) chk("done_latency", n, 36);
      chk("busy_in_done_cycle", busy, 1);
      if (start_done) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      chk("valid_after_done", out_valid, 0);
      @(posedge clk); #1;
      chk("no_restart", busy | out_valid, 0);
      @(negedge clk);
      chk("beats_accepted", acc_cnt, 36);
      chk("done_count", done_cnt, 1);
      chk("sb_empty", sbq.size(), 0);
      check_pool_res();
   endtask

   initial begin
      int nz;
      rst_n     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 144; i++) fmap[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_idx", out_idx, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // 1. Ramp
      for (int i = 0; i < 144; i++) fmap[i] = 36'(i);
      run_pool(0, 0, 0, 1);
      chk("ramp_idx0", pool_res[0], 7);
      chk("ramp_idx1", pool_res[1], 9);
      chk("ramp_idx3", pool_res[3], 19);
      chk("ramp_idx35", pool_res[35], 143);

      // 2. Negatives and ties
      for (int i = 0; i < 144; i++) fmap[i] = rnd36();
      fmap[0] = -36'sd5;  fmap[1] = -36'sd5;  fmap[6] = -36'sd9;  fmap[7] = -36'sd20;
      fmap[2] = '0;       fmap[3] = '0;       fmap[8] = '0;       fmap[9] = '0;
      run_pool(0, 0, 0, 0);
      chk("neg_window0", pool_res[0], -64'sd5);
      chk("zero_window1", pool_res[1], 0);

      // 3. Backpressure 1,0,0,1
      for (int i = 0; i < 144; i++) fmap[i] = rnd36();
      rphase = 0;
      run_pool(1, 0, 0, 0);

      // 4. start while busy, and start on the done cycle
      for (int i = 0; i < 144; i++) fmap[i] = rnd36();
      run_pool(0, 1, 1, 1);

      // 5. Reset mid-run
      for (int i = 0; i < 144; i++) fmap[i] = rnd36();
      ready_mode = 0;
      build_gold();
      acc_cnt  = 0;
      done_cnt = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int n = 0; n < 500 && acc_cnt < 20; n++) begin
         @(posedge clk); #1;
      end
      chk("reset_reached_beat20", acc_cnt, 20);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_data", out_data, 0);
      chk("abort_idx", out_idx, 0);
      nz = 0;
      for (int k = 0; k < 36; k++) if (pool_res[k] !== '0) nz++;
      chk("abort_pool_res_nonzero", nz, 0);
      sbq.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("abort_no_done", done_cnt, 0);
      for (int i = 0; i < 144; i++) fmap[i] = rnd36();
      run_pool(0, 0, 0, 1);

      // 6. Max magnitude, directed windows then random runs
      for (int i = 0; i < 144; i++) fmap[i] = rnd36();
      fmap[0] = MINN; fmap[1] = MINN; fmap[6] = MINN; fmap[7] = MINN;
      fmap[2] = MINN; fmap[3] = MAXP; fmap[8] = MINN; fmap[9] = MINN;
      run_pool(2, 0, 0, 0);
      chk("all_min_window", pool_res[0], 64'(MINN));
      chk("max_in_min_window", pool_res[1], 64'(MAXP));
      for (int run = 0; run < 100; run++) begin
         for (int i = 0; i < 144; i++) begin
            case ($urandom_range(0, 3))
               0: fmap[i] = MAXP;
               1: fmap[i] = MINN;
               2: fmap[i] = MAXP - 36'sd1;
               default: fmap[i] = rnd36();
            endcase
         end
         run_pool(int'($urandom_range(0, 2)), 0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
